// File: rtl/spu_pkg.sv
// Shared types for the SPU fixed-latency issue logic: pipe latency, register
// address type and the scoreboard slot layout.
package spu_pkg;

    localparam int unsigned FX2_LAT = 5;
    localparam int unsigned REG_AW  = 7;

    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t addr;
    } sb_slot_t;

endpackage

// File: rtl/fx_scoreboard.sv
// Shift-register scoreboard of in-flight destination registers with two
// parallel source-address match ports.
module fx_scoreboard
    import spu_pkg::*;
#(
    parameter int unsigned LAT = FX2_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush_i,
    input  logic              load_valid_i,
    input  logic [REG_AW-1:0] load_addr_i,
    input  logic [REG_AW-1:0] ra_addr_i,
    input  logic [REG_AW-1:0] rb_addr_i,
    output logic              ra_hit_o,
    output logic              rb_hit_o,
    output logic [LAT-1:0]    busy_mask_o
);

    sb_slot_t slots_q [LAT];
    sb_slot_t slots_d [LAT];

    always_comb begin
        slots_d[0].valid = load_valid_i;
        slots_d[0].addr  = load_addr_i;
        for (int i = 1; i < LAT; i++) begin
            slots_d[i] = slots_q[i-1];
        end
        // Flush wins over the shift and the slot-0 load.
        if (flush_i) begin
            for (int i = 0; i < LAT; i++) begin
                slots_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < LAT; i++) begin
                slots_q[i] <= '0;
            end
        end else begin
            slots_q <= slots_d;
        end
    end

    always_comb begin
        ra_hit_o    = 1'b0;
        rb_hit_o    = 1'b0;
        busy_mask_o = '0;
        for (int i = 0; i < LAT; i++) begin
            busy_mask_o[i] = slots_q[i].valid;
            if (slots_q[i].valid && (slots_q[i].addr == ra_addr_i)) ra_hit_o = 1'b1;
            if (slots_q[i].valid && (slots_q[i].addr == rb_addr_i)) rb_hit_o = 1'b1;
        end
    end

endmodule

// File: rtl/fx2_issue_ctrl.sv
// Issue control for the simple-fixed-2 pipe: RAW hazard stall against a
// fixed-latency scoreboard, registered issue outputs and a stall counter.
module fx2_issue_ctrl
    import spu_pkg::*;
#(
    parameter int unsigned LAT = FX2_LAT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [REG_AW-1:0] in_rt_addr_i,
    input  logic [REG_AW-1:0] in_ra_addr_i,
    input  logic [REG_AW-1:0] in_rb_addr_i,
    input  logic              in_uses_ra_i,
    input  logic              in_uses_rb_i,
    input  logic              in_reg_write_i,
    input  logic              flush_i,
    output logic              issue_valid_o,
    output logic [REG_AW-1:0] issue_rt_addr_o,
    output logic              issue_reg_write_o,
    output logic [LAT-1:0]    busy_mask_o,
    output logic [15:0]       stall_count_o
);

    logic              ra_hit;
    logic              rb_hit;
    logic              hazard;
    logic              accept;
    logic              load_valid;
    logic [REG_AW-1:0] load_addr;

    logic              issue_valid_q,     issue_valid_d;
    logic [REG_AW-1:0] issue_rt_addr_q,   issue_rt_addr_d;
    logic              issue_reg_write_q, issue_reg_write_d;
    logic [15:0]       stall_count_q,     stall_count_d;

    fx_scoreboard #(
        .LAT (LAT)
    ) u_scoreboard (
        .clk          (clk),
        .reset        (reset),
        .flush_i      (flush_i),
        .load_valid_i (load_valid),
        .load_addr_i  (load_addr),
        .ra_addr_i    (in_ra_addr_i),
        .rb_addr_i    (in_rb_addr_i),
        .ra_hit_o     (ra_hit),
        .rb_hit_o     (rb_hit),
        .busy_mask_o  (busy_mask_o)
    );

    always_comb begin
        hazard     = in_valid_i & ((in_uses_ra_i & ra_hit) | (in_uses_rb_i & rb_hit));
        in_ready_o = ~hazard;
        accept     = in_valid_i & ~hazard;
        load_valid = accept & in_reg_write_i;
        load_addr  = accept ? in_rt_addr_i : '0;

        // An acceptance in a flush cycle is dropped.
        issue_valid_d     = accept & ~flush_i;
        issue_rt_addr_d   = issue_valid_d ? in_rt_addr_i : '0;
        issue_reg_write_d = issue_valid_d & in_reg_write_i;

        stall_count_d = stall_count_q;
        if (hazard && (stall_count_q != 16'hFFFF)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_valid_q     <= 1'b0;
            issue_rt_addr_q   <= '0;
            issue_reg_write_q <= 1'b0;
            stall_count_q     <= '0;
        end else begin
            issue_valid_q     <= issue_valid_d;
            issue_rt_addr_q   <= issue_rt_addr_d;
            issue_reg_write_q <= issue_reg_write_d;
            stall_count_q     <= stall_count_d;
        end
    end

    assign issue_valid_o     = issue_valid_q;
    assign issue_rt_addr_o   = issue_rt_addr_q;
    assign issue_reg_write_o = issue_reg_write_q;
    assign stall_count_o     = stall_count_q;

endmodule
